// File: rtl/i2s_tx_sched.sv
// i2s_tx_sched: stereo I2S transmit scheduler with sample-pair FIFO; `define I2S_TX_UNDERRUN_ZERO_EN streams zero frames on underrun
module i2s_tx_sched #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_left,
    input  logic [WORD_W-1:0] s_right,
    output logic              vld_o,
    output logic              ws_o,
    output logic              sd_o,
    output logic              busy,
    output logic [CNT_W-1:0]  underrun_cnt
);
    localparam int KW = $clog2(WORD_W);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, TAIL} state_t;
    state_t state, state_nx;
    logic [KW-1:0] k, idx;
    logic [WORD_W-1:0] left_q, right_q;
    logic [WORD_W-1:0] mem_l [DEPTH];
    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic prev_r0, first, push, pop, zero_ld, last, vld_c, ws_c, sd_c;
    assign s_ready = count < (AW+1)'(DEPTH);
    assign push = s_valid && s_ready;
    assign last = k == KW'(WORD_W-1);
    assign idx = ~k + KW'(1);
    assign busy = state != IDLE;
    always_comb begin
        state_nx = state;
        pop = 1'b0;
        zero_ld = 1'b0;
        case (state)
            IDLE: if (en && count != '0) begin
                pop = 1'b1;
                state_nx = LEFT;
            end
            LEFT: if (last) state_nx = RIGHT;
            RIGHT: if (last) begin
                if (en && count != '0) begin
                    pop = 1'b1;
                    state_nx = LEFT;
                end
`ifdef I2S_TX_UNDERRUN_ZERO_EN
                else if (en) begin
                    zero_ld = 1'b1;
                    state_nx = LEFT;
                end
`endif
                else state_nx = TAIL;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Slot bit k>=1 carries word[WORD_W-k]; k=0 carries the previous word's LSB (I2S one-bit delay)
    always_comb begin
        vld_c = state == LEFT || state == RIGHT;
        ws_c = state == LEFT ? 1'b0 : state == IDLE ? ws_o : 1'b1;
        sd_c = state == IDLE ? sd_o :
               state == TAIL ? right_q[0] :
               state == LEFT ? (k == '0 ? (!first && prev_r0) : left_q[idx]) :
                               (k == '0 ? left_q[0] : right_q[idx]);
    end
    always_ff @(posedge clk) if (push) begin
        mem_l[wr_ptr] <= s_left;
        mem_r[wr_ptr] <= s_right;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k <= '0;
            left_q <= '0;
            right_q <= '0;
            prev_r0 <= 1'b0;
            first <= 1'b0;
            vld_o <= 1'b0;
            ws_o <= 1'b0;
            sd_o <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            state <= state_nx;
            k <= vld_c ? k + 1'b1 : '0;
            vld_o <= vld_c;
            ws_o <= ws_c;
            sd_o <= sd_c;
            if (pop || zero_ld) begin
                left_q <= pop ? mem_l[rd_ptr] : '0;
                right_q <= pop ? mem_r[rd_ptr] : '0;
                prev_r0 <= right_q[0];
                first <= state == IDLE;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
`ifdef I2S_TX_UNDERRUN_ZERO_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) underrun_cnt <= '0;
        else if (zero_ld && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
`else
    assign underrun_cnt = '0;
`endif
endmodule

// File: tb/tb_i2s_tx_sched.sv
// tb_i2s_tx_sched: directed self-checking bench for i2s_tx_sched (default build; I2S_TX_UNDERRUN_ZERO_EN selects the zero-frame test)
module tb_i2s_tx_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic s_valid = 1'b0;
    logic s_ready;
    logic [31:0] s_left = '0;
    logic [31:0] s_right = '0;
    logic vld_o, ws_o, sd_o, busy;
    logic [7:0] underrun_cnt;
    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] cv, cw, cd;
    logic [63:0] ws_exp = {32'h0000_0000, 32'hFFFF_FFFF};
    logic [63:0] vld_exp = '1;
    logic [31:0] pl [5];
    logic [31:0] pr [5];

    i2s_tx_sched #(.WORD_W(32), .DEPTH(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_ready(s_ready),
        .s_left(s_left), .s_right(s_right), .vld_o(vld_o), .ws_o(ws_o), .sd_o(sd_o),
        .busy(busy), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Records one 64-cycle frame, first sample in bit 63
    task automatic capture(output logic [63:0] v, output logic [63:0] w, output logic [63:0] d);
        for (int j = 0; j < 64; j++) begin
            v[63-j] = vld_o;
            w[63-j] = ws_o;
            d[63-j] = sd_o;
            tick();
        end
    endtask

    task automatic test_reset;
        repeat (3) tick();
        n_chk += 6;
        if (vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", vld_o); end
        if (ws_o !== 1'b0) begin n_fail++; $display("FAIL reset_ws: got %b expected 0", ws_o); end
        if (sd_o !== 1'b0) begin n_fail++; $display("FAIL reset_sd: got %b expected 0", sd_o); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", s_ready); end
        if (underrun_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", underrun_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        logic [31:0] l = 32'h8000_0001;
        logic [31:0] r = 32'h0000_FFFF;
        en = 1'b1;
        s_left = l;
        s_right = r;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        n_chk += 2;
        if (vld_o !== 1'b0) begin n_fail++; $display("FAIL single_vld_t: got %b expected 0", vld_o); end
        tick();
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_t1: got %b expected 1", busy); end
        tick();
        capture(cv, cw, cd);
        n_chk += 5;
        if (cv !== vld_exp) begin n_fail++; $display("FAIL single_vld: got %h expected %h", cv, vld_exp); end
        if (cw !== ws_exp) begin n_fail++; $display("FAIL single_ws: got %h expected %h", cw, ws_exp); end
        if (cd !== {1'b0, l, r[31:1]}) begin n_fail++; $display("FAIL single_sd: got %h expected %h", cd, {1'b0, l, r[31:1]}); end
        if (cd[62] !== 1'b1) begin n_fail++; $display("FAIL single_msb_t3: got %b expected 1", cd[62]); end
        if (cd[61] !== 1'b0) begin n_fail++; $display("FAIL single_t4: got %b expected 0", cd[61]); end
        n_chk += 3;
        if (vld_o !== 1'b0) begin n_fail++; $display("FAIL single_tail_vld: got %b expected 0", vld_o); end
        if (ws_o !== 1'b1) begin n_fail++; $display("FAIL single_tail_ws: got %b expected 1", ws_o); end
        if (sd_o !== 1'b1) begin n_fail++; $display("FAIL single_tail_sd: got %b expected 1", sd_o); end
        tick();
        n_chk += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_t67: got %b expected 0", busy); end
        if (vld_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_vld: got %b expected 0", vld_o); end
        if (underrun_cnt !== 8'd0) begin n_fail++; $display("FAIL single_cnt: got %0d expected 0", underrun_cnt); end
        en = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] l [3] = '{32'hA5A5_0F0F, 32'h0000_0003, 32'hCAFE_BABE};
        logic [31:0] r [3] = '{32'h1234_5671, 32'hFFFF_0000, 32'h8000_0001};
        logic [31:0] rp;
        logic pv;
        en = 1'b0;
        s_valid = 1'b1;
        s_left = l[0];
        s_right = r[0];
        tick();
        n_chk += 1;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b expected 1", s_ready); end
        s_left = l[1];
        s_right = r[1];
        tick();
        n_chk += 1;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %b expected 0", s_ready); end
        s_left = l[2];
        s_right = r[2];
        en = 1'b1;
        tick();
        n_chk += 1;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_reopen: got %b expected 1", s_ready); end
        tick();
        s_valid = 1'b0;
        pv = 1'b0;
        for (int f = 0; f < 3; f++) begin
            capture(cv, cw, cd);
            rp = r[f];
            n_chk += 3;
            if (cv !== vld_exp) begin n_fail++; $display("FAIL b2b_vld%0d: got %h expected %h", f, cv, vld_exp); end
            if (cw !== ws_exp) begin n_fail++; $display("FAIL b2b_ws%0d: got %h expected %h", f, cw, ws_exp); end
            if (cd !== {pv, l[f], rp[31:1]}) begin n_fail++; $display("FAIL b2b_sd%0d: got %h expected %h", f, cd, {pv, l[f], rp[31:1]}); end
            pv = rp[0];
        end
        n_chk += 2;
        if (vld_o !== 1'b0) begin n_fail++; $display("FAIL b2b_tail_vld: got %b expected 0", vld_o); end
        if (sd_o !== 1'b1) begin n_fail++; $display("FAIL b2b_tail_sd: got %b expected 1", sd_o); end
        tick();
        en = 1'b0;
    endtask

    task automatic test_en_drop;
        logic [31:0] l0 = 32'h1357_9BDF;
        logic [31:0] r0 = 32'h0F0F_F0F1;
        logic [31:0] l1 = 32'h7654_3210;
        logic [31:0] r1 = 32'hAAAA_5554;
        en = 1'b0;
        s_valid = 1'b1;
        s_left = l0;
        s_right = r0;
        tick();
        s_left = l1;
        s_right = r1;
        tick();
        s_valid = 1'b0;
        en = 1'b1;
        tick();
        tick();
        fork
            capture(cv, cw, cd);
            begin
                repeat (4) tick();
                en = 1'b0;
            end
        join
        n_chk += 4;
        if (cv !== vld_exp) begin n_fail++; $display("FAIL drop_vld: got %h expected %h", cv, vld_exp); end
        if (cd !== {1'b0, l0, r0[31:1]}) begin n_fail++; $display("FAIL drop_sd: got %h expected %h", cd, {1'b0, l0, r0[31:1]}); end
        if (vld_o !== 1'b0) begin n_fail++; $display("FAIL drop_tail_vld: got %b expected 0", vld_o); end
        if (sd_o !== 1'b1) begin n_fail++; $display("FAIL drop_tail_sd: got %b expected 1", sd_o); end
        repeat (5) tick();
        n_chk += 2;
        if (vld_o !== 1'b0) begin n_fail++; $display("FAIL drop_idle_vld: got %b expected 0", vld_o); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle_busy: got %b expected 0", busy); end
        en = 1'b1;
        tick();
        n_chk += 1;
        if (vld_o !== 1'b0) begin n_fail++; $display("FAIL drop_resume_early: got %b expected 0", vld_o); end
        tick();
        capture(cv, cw, cd);
        n_chk += 3;
        if (cv !== vld_exp) begin n_fail++; $display("FAIL drop_p2_vld: got %h expected %h", cv, vld_exp); end
        if (cw !== ws_exp) begin n_fail++; $display("FAIL drop_p2_ws: got %h expected %h", cw, ws_exp); end
        if (cd !== {1'b0, l1, r1[31:1]}) begin n_fail++; $display("FAIL drop_p2_sd: got %h expected %h", cd, {1'b0, l1, r1[31:1]}); end
        n_chk += 1;
        if (sd_o !== 1'b0) begin n_fail++; $display("FAIL drop_p2_tail_sd: got %b expected 0", sd_o); end
        en = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid;
        int hits = 0;
        en = 1'b0;
        s_valid = 1'b1;
        s_left = 32'h0F0F_0F0F;
        s_right = 32'hFFFF_FFFF;
        tick();
        s_left = 32'h1111_1111;
        s_right = 32'h2222_2222;
        tick();
        s_valid = 1'b0;
        en = 1'b1;
        tick();
        repeat (42) tick();
        n_chk += 2;
        if (vld_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_vld: got %b expected 1", vld_o); end
        if (sd_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_sd: got %b expected 1", sd_o); end
        rst_n = 1'b0;
        #1;
        n_chk += 5;
        if (vld_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_vld: got %b expected 0", vld_o); end
        if (ws_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ws: got %b expected 0", ws_o); end
        if (sd_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_sd: got %b expected 0", sd_o); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", s_ready); end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vld_o || busy) hits++;
        end
        n_chk += 1;
        if (hits !== 0) begin n_fail++; $display("FAIL rstmid_residual: got %0d active cycles expected 0", hits); end
        en = 1'b0;
    endtask

    task automatic test_random_gaps;
        logic mv [900];
        logic mw [900];
        logic md [900];
        logic [31:0] gl, gr;
        int nf = 0;
        pl = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1357_9BDF, 32'hFFFF_FFFF, 32'h0000_0001};
        pr = '{32'h1234_5678, 32'hFEED_FACE, 32'h2468_ACE0, 32'h0000_0000, 32'h8000_0000};
        en = 1'b1;
        fork
            for (int i = 0; i < 5; i++) begin
                int guard = 0;
                repeat ($urandom_range(0, 40)) tick();
                s_left = pl[i];
                s_right = pr[i];
                s_valid = 1'b1;
                while (!s_ready && guard < 1000) begin
                    tick();
                    guard++;
                end
                tick();
                s_valid = 1'b0;
            end
            for (int c = 0; c < 900; c++) begin
                mv[c] = vld_o;
                mw[c] = ws_o;
                md[c] = sd_o;
                tick();
            end
        join
        for (int c = 1; c < 900 - 65; c++) begin
            if (mv[c] && !mw[c] && (!mv[c-1] || mw[c-1])) begin
                for (int i = 0; i < 32; i++) begin
                    gl[31-i] = md[c+1+i];
                    gr[31-i] = md[c+33+i];
                end
                if (nf < 5) begin
                    n_chk += 2;
                    if (gl !== pl[nf]) begin n_fail++; $display("FAIL rand_left%0d: got %h expected %h", nf, gl, pl[nf]); end
                    if (gr !== pr[nf]) begin n_fail++; $display("FAIL rand_right%0d: got %h expected %h", nf, gr, pr[nf]); end
                end
                nf++;
            end
        end
        n_chk += 1;
        if (nf !== 5) begin n_fail++; $display("FAIL rand_frames: got %0d expected 5", nf); end
        en = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_underrun_zero;
        en = 1'b1;
        s_left = 32'h8000_0001;
        s_right = 32'h0000_0001;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        repeat (64) tick();
        n_chk += 1;
        if (underrun_cnt !== 8'd0) begin n_fail++; $display("FAIL uz_cnt_before: got %0d expected 0", underrun_cnt); end
        tick();
        n_chk += 1;
        if (underrun_cnt !== 8'd1) begin n_fail++; $display("FAIL uz_cnt_first: got %0d expected 1", underrun_cnt); end
        repeat (300 * 64) tick();
        n_chk += 2;
        if (underrun_cnt !== 8'd255) begin n_fail++; $display("FAIL uz_cnt_sat: got %0d expected 255", underrun_cnt); end
        if (vld_o !== 1'b1) begin n_fail++; $display("FAIL uz_stream: got %b expected 1", vld_o); end
        en = 1'b0;
        repeat (70) tick();
        n_chk += 1;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL uz_stop: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
`ifdef I2S_TX_UNDERRUN_ZERO_EN
        test_underrun_zero();
`else
        test_single();
        test_back_to_back();
        test_en_drop();
        test_reset_mid();
        test_random_gaps();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_tx_sched.md
Name: i2s_tx_sched

Overview:
- Stereo transmit scheduler for the audio serial path.
- Buffers left/right sample pairs from a producer through a valid/ready FIFO.
- Sequences each pair onto the serial stream: vld_o framing, ws_o word select, sd_o serial data, MSB-first, with the I2S one-bit data delay.
- Sits upstream of the I2S receive deserializer and is the block that drives its in_valid/WS/SD inputs.

Parameters:
- WORD_W, 32, bits per channel word; slot length in clk cycles.
- DEPTH, 2, sample-pair FIFO entries (power of two, >=2).
- CNT_W, 8, underrun counter width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  streaming enable, sampled at frame boundaries.
- s_valid  input  1  producer pair valid.
- s_ready  output  1  FIFO not full.
- s_left  input  WORD_W  left sample.
- s_right  input  WORD_W  right sample.
- vld_o  output  1  serial stream valid (in_valid of receiver).
- ws_o  output  1  word select: 0 = left, 1 = right.
- sd_o  output  1  serial data.
- busy  output  1  state != IDLE.
- underrun_cnt  output  CNT_W  saturating underrun count.

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset values: vld_o=0, ws_o=0, sd_o=0, busy=0, underrun_cnt=0, FIFO empty, s_ready=1. Reset mid-frame aborts immediately; no tail cycle is emitted.
- FIFO: push when s_valid && s_ready. s_ready = count < DEPTH, from registered count.
  - No fall-through: a pair pushed at cycle t is poppable at t+1.
  - Push and pop in the same cycle are allowed when not full.
  - Pointers wrap modulo DEPTH; order is preserved.
- All serial outputs are registered.
- States and transitions:
  - IDLE: vld_o=0; ws_o and sd_o hold their last values. When en && FIFO non-empty: pop the pair into the shift registers and go to LEFT with k=0.
  - LEFT, slot cycle k=0..WORD_W-1: vld_o=1, ws_o=0. sd_o = 0 at k=0 of the first frame after IDLE; otherwise sd_o = previous right[0] at k=0. For k>=1, sd_o = left[WORD_W-k]. After k=WORD_W-1, go to RIGHT.
  - RIGHT, k=0..WORD_W-1: vld_o=1, ws_o=1. sd_o = left[0] at k=0; right[WORD_W-k] for k>=1.
  - End of RIGHT (k=WORD_W-1):
    - If en && FIFO non-empty: pop and go to LEFT. Frames are back-to-back with no gap.
    - Otherwise go to TAIL.
  - TAIL, one cycle: vld_o=0, ws_o=1 (held), sd_o=right[0]. Then go to IDLE.
- Frame = 2*WORD_W cycles. en deasserted mid-frame never truncates: the current pair completes, then TAIL.
- Latency: a pair pushed at cycle t into an empty FIFO while IDLE with en=1 gives vld_o=1 at t+2, and the left MSB on sd_o at t+3.
- Slot counter: log2(WORD_W) bits, wraps at WORD_W-1.

Optional Feature:
- Macro I2S_TX_UNDERRUN_ZERO_EN.
- Defined: at the end of RIGHT with en=1 and FIFO empty, load a zero pair and continue to LEFT; the stream does not stop. underrun_cnt increments by 1 per zero frame and saturates at 2^CNT_W-1. en=0 still goes to TAIL.
- Undefined: underrun goes to TAIL, then IDLE; underrun_cnt is tied to 0.

Test Plan:
- One pair L=0x80000001, R=0x0000FFFF pushed at t, en=1 -> vld_o high t+2..t+65; ws_o=0 for 32 cycles, then 1 for 32; sd_o=1 at t+3, 0 at t+4; tail at t+66 with vld_o=0, sd_o=1; busy=0 at t+67.
- Push 3 pairs back-to-back, DEPTH=2 -> s_ready drops after 2 entries, reopens on pop; vld_o continuous for 192 cycles; ws_o toggles every 32; L/R order matches push order.
- Two pairs queued, en dropped at LEFT k=5 of pair 1 -> pair 1 completes, tail, IDLE with pair 2 retained; en=1 -> pair 2 streams 2 cycles later.
- rst_n low at RIGHT k=10 -> vld_o/sd_o/ws_o/busy=0 immediately; s_ready=1; after release, no residual output.
- Macro defined, one pair pushed, en held -> zero frames follow; underrun_cnt=1 after the first empty boundary; 300 frames later it reads 255. Macro undefined -> tail, IDLE, cnt=0.
- 5 pairs (0xDEADBEEF/0x12345678 etc.) pushed with random s_valid gaps and en=1 -> every pair serialized exactly once, in order; FIFO wraps correctly; no extra frames.
